mips_fetch_unit: RTL

//  Instruction fetch stage upstream of the MiniMIPS decode/control path. Owns the PC,

---
 rtl/mips_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_fetch_unit.sv
//------------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction fetch stage feeding the MiniMIPS decode/control path. Owns the
// fetch PC and issues in-order requests to a variable-latency instruction
// memory. Returned 16-bit instructions are buffered in a DEPTH-entry prefetch
// queue and handed to decode as {pc, instr} over a valid/ready handshake.
// A taken branch (redirect_valid) flushes the queue and restarts fetch at
// redirect_pc. Responses to requests that were in flight at the redirect are
// still returned by the memory, so they are counted and discarded (DRAIN).
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   redirect_valid/_pc      flush and refetch from redirect_pc
//   mem_req/mem_addr        fetch request and its word address
//   mem_gnt                 request accepted (mem_req & mem_gnt)
//   mem_rvalid/mem_rdata    in-order response
//   instr_valid/_ready      decode handshake (pop on valid & ready)
//   instr_data/instr_pc     queue head instruction and its address
//   perf_stall_cnt          only with FETCH_PERF_EN: saturating count of
//                           cycles where decode was ready but nothing was valid
//
// Build macro: FETCH_PERF_EN (undefined by default) adds perf_stall_cnt.
//------------------------------------------------------------------------------

module mips_fetch_unit_chk #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input logic             clk,
   input logic             rst_n,
   input logic             push,
   input logic             rvalid,
   input logic [CNT_W-1:0] count,
   input logic [CNT_W-1:0] outstanding,
   input logic [CNT_W-1:0] discard
);

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W:0] credit_sum_s;

   assign credit_sum_s = {1'b0, count} + {1'b0, outstanding};

   // Structural invariants of the queue/credit bookkeeping, sampled each edge outside reset.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(push && (count == DEPTH_C)))
            else $error("mips_fetch_unit: push into full prefetch queue");
         assert (discard <= outstanding)
            else $error("mips_fetch_unit: discard exceeds outstanding");
         assert (credit_sum_s <= {1'b0, DEPTH_C})
            else $error("mips_fetch_unit: queued + outstanding exceeds DEPTH");
         assert (!(rvalid && (outstanding == CNT_ZERO)))
            else $error("mips_fetch_unit: response with no outstanding request");
      end
   end

endmodule

module mips_fetch_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INSTR_W  = 16,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt
`endif
);

   localparam int unsigned        PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned        CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]   PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]   PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [INSTR_W-1:0] DATA_ZERO = {INSTR_W{1'b0}};

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // Architectural state
   logic [ADDR_W-1:0]  fetch_pc_r;
   logic [ADDR_W-1:0]  resp_pc_r;
   logic [CNT_W-1:0]   outstanding_r;
   logic [CNT_W-1:0]   discard_r;
   logic [0:0]         state_r;

   // Prefetch queue
   logic [CNT_W-1:0]   count_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [ADDR_W-1:0]  q_pc_r   [DEPTH];
   logic [INSTR_W-1:0] q_data_r [DEPTH];
   logic [ADDR_W-1:0]  last_pc_r;
   logic [INSTR_W-1:0] last_data_r;

   // Combinational control
   logic [CNT_W:0]     credit_sum_s;
   logic               req_s;
   logic               grant_s;
   logic               valid_s;
   logic               push_s;
   logic               pop_s;
   logic [CNT_W-1:0]   outstanding_nxt_s;
   logic [CNT_W-1:0]   redirect_discard_s;
   logic [CNT_W-1:0]   discard_nxt_s;
   logic [0:0]         state_nxt_s;
   logic [ADDR_W-1:0]  head_pc_s;
   logic [INSTR_W-1:0] head_data_s;

   // Handshake decode. Every outstanding request owns a queue slot, so a
   // response can never find the queue full. rst_n gates the request so it
   // drops the moment reset asserts, without waiting for a clock.
   always_comb begin
      credit_sum_s = {1'b0, outstanding_r} + {1'b0, count_r};
      req_s        = rst_n & ~redirect_valid & (credit_sum_s < {1'b0, DEPTH_C});
      grant_s      = req_s & mem_gnt;
      valid_s      = (count_r != CNT_ZERO);
      push_s       = mem_rvalid & ~redirect_valid & (state_r == ST_RUN);
      pop_s        = valid_s & instr_ready & ~redirect_valid;
   end

   // Outstanding tracking plus RUN/DRAIN next state. On a redirect every
   // request still in flight after this cycle's response is stale, including
   // any that were already marked for discard.
   always_comb begin
      outstanding_nxt_s  = outstanding_r + (grant_s ? CNT_ONE : CNT_ZERO)
                                         - (mem_rvalid ? CNT_ONE : CNT_ZERO);
      redirect_discard_s = outstanding_r - (mem_rvalid ? CNT_ONE : CNT_ZERO);
      discard_nxt_s      = discard_r;
      state_nxt_s        = state_r;
      if (redirect_valid) begin
         discard_nxt_s = redirect_discard_s;
         if (redirect_discard_s != CNT_ZERO) begin
            state_nxt_s = ST_DRAIN;
         end else begin
            state_nxt_s = ST_RUN;
         end
      end else begin
         case (state_r)
            ST_RUN: begin
               discard_nxt_s = CNT_ZERO;
               state_nxt_s   = ST_RUN;
            end
            ST_DRAIN: begin
               if (mem_rvalid) begin
                  discard_nxt_s = discard_r - CNT_ONE;
                  if (discard_r == CNT_ONE) begin
                     state_nxt_s = ST_RUN;
                  end else begin
                     state_nxt_s = ST_DRAIN;
                  end
               end else begin
                  discard_nxt_s = discard_r;
                  state_nxt_s   = ST_DRAIN;
               end
            end
            default: begin
               discard_nxt_s = CNT_ZERO;
               state_nxt_s   = ST_RUN;
            end
         endcase
      end
   end

   // Fetch/response PCs, outstanding count and FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         outstanding_r <= CNT_ZERO;
         discard_r     <= CNT_ZERO;
         state_r       <= ST_RUN;
      end else begin
         outstanding_r <= outstanding_nxt_s;
         discard_r     <= discard_nxt_s;
         state_r       <= state_nxt_s;
         if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            resp_pc_r  <= redirect_pc;
         end else begin
            if (grant_s) begin
               fetch_pc_r <= fetch_pc_r + ADDR_ONE;
            end
            if (push_s) begin
               resp_pc_r <= resp_pc_r + ADDR_ONE;
            end
         end
      end
   end

   // Queue occupancy and pointers; a redirect empties the queue and voids any pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r  <= CNT_ZERO;
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else if (redirect_valid) begin
         count_r  <= CNT_ZERO;
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else begin
         count_r <= count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Queue storage: each entry carries the address it was fetched from.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_pc_r[i]   <= ADDR_ZERO;
            q_data_r[i] <= DATA_ZERO;
         end
      end else if (push_s) begin
         q_pc_r[wr_ptr_r]   <= resp_pc_r;
         q_data_r[wr_ptr_r] <= mem_rdata;
      end
   end

   // Remember the most recently presented head so the outputs hold while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_pc_r   <= ADDR_ZERO;
         last_data_r <= DATA_ZERO;
      end else if (valid_s) begin
         last_pc_r   <= head_pc_s;
         last_data_r <= head_data_s;
      end
   end

   assign head_pc_s   = q_pc_r[rd_ptr_r];
   assign head_data_s = q_data_r[rd_ptr_r];

   assign mem_req     = req_s;
   assign mem_addr    = fetch_pc_r;
   assign instr_valid = valid_s;
   assign instr_pc    = valid_s ? head_pc_s   : last_pc_r;
   assign instr_data  = valid_s ? head_data_s : last_data_r;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cnt_r;

   // Count cycles where decode was ready but had nothing to take; saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt_r <= 32'h0000_0000;
      end else if (instr_ready && !valid_s && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
         perf_stall_cnt_r <= perf_stall_cnt_r + 32'h0000_0001;
      end
   end

   assign perf_stall_cnt = perf_stall_cnt_r;
`endif

   mips_fetch_unit_chk #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push_s),
      .rvalid      (mem_rvalid),
      .count       (count_r),
      .outstanding (outstanding_r),
      .discard     (discard_r)
   );

endmodule
